// File: rtl/mem_req_arbiter_if.sv
// Request/RAM bundle between the datapath requesters, the memory arbiter and the RAM port.
// The arbiter connects through the slave modport; the requesters and RAM side use master.
interface mem_req_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        ram_ready;
  logic [31:0] ramload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic        iwait;
  logic        dwait;
  logic [31:0] iload;
  logic [31:0] dload;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ram_ready, ramload,
    output ramREN, ramWEN, ramaddr, ramstore, iwait, dwait, iload, dload
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ram_ready, ramload,
    input  ramREN, ramWEN, ramaddr, ramstore, iwait, dwait, iload, dload
  );
endinterface

// File: rtl/mem_req_arbiter.sv
// Serialises instruction-fetch and data requests onto one RAM port. Data has priority, and a
// starvation counter forces one fetch after STARVE_LIMIT data grants while a fetch is pending.
module mem_req_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input logic               CLK,
  input logic               nRST,
  mem_req_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } state_t;

  localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

  state_t     state_r;
  logic [3:0] starve_r;
  logic       dReq_s;
  logic       iDone_s;
  logic       dDone_s;
  logic       dataWins_s;

  assign dReq_s     = bus.dREN | bus.dWEN;
  assign iDone_s    = (state_r == IGNT) & bus.ram_ready;
  assign dDone_s    = (state_r == DGNT) & bus.ram_ready & dReq_s;
  assign dataWins_s = dReq_s & (~bus.iREN | (starve_r < LIMIT_C));

  // Grant state machine and starvation counter; every grant returns through IDLE.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r  <= IDLE;
      starve_r <= 4'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (dataWins_s) begin
            state_r <= DGNT;
          end else if (bus.iREN) begin
            state_r <= IGNT;
          end else begin
            state_r <= IDLE;
          end
        end
        IGNT: begin
          if (bus.ram_ready || !bus.iREN) begin
            state_r <= IDLE;
          end else begin
            state_r <= IGNT;
          end
        end
        DGNT: begin
          if (bus.ram_ready || !dReq_s) begin
            state_r <= IDLE;
          end else begin
            state_r <= DGNT;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase

      // The count only matters while a fetch is waiting, so it restarts whenever none is.
      if (!bus.iREN || iDone_s) begin
        starve_r <= 4'd0;
      end else if (dDone_s && (starve_r != 4'd15)) begin
        starve_r <= starve_r + 4'd1;
      end else begin
        starve_r <= starve_r;
      end
    end
  end

  // RAM strobes and load steering follow the grant state directly.
  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = 32'd0;
    bus.ramstore = 32'd0;
    bus.iload    = 32'd0;
    bus.dload    = 32'd0;
    case (state_r)
      IGNT: begin
        bus.ramREN  = 1'b1;
        bus.ramaddr = bus.iaddr;
        bus.iload   = bus.ramload;
      end
      DGNT: begin
        bus.ramaddr = bus.daddr;
        if (bus.dWEN) begin
          bus.ramWEN   = 1'b1;
          bus.ramstore = bus.dstore;
        end else begin
          bus.ramREN = 1'b1;
          bus.dload  = bus.ramload;
        end
      end
      default: begin
        bus.ramREN = 1'b0;
      end
    endcase
  end

  assign bus.iwait = bus.iREN & ~iDone_s;
  assign bus.dwait = dReq_s & ~((state_r == DGNT) & bus.ram_ready);

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: directed scenarios plus a randomized phase, all checked by a
// scoreboard of expected completions and a transaction-level model of the grant policy.
module tb_mem_req_arbiter;
  localparam int LIMIT = 4;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;

  mem_req_arbiter_if bus();

  mem_req_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t iQ[$];
  txn_t dQ[$];
  int   tests    = 0;
  int   fails    = 0;
  int   iDoneCnt = 0;
  int   dDoneCnt = 0;
  int   served   = 0;   // data services completed while a fetch has been waiting
  int   expG     = -1;  // -1 none, 0 stay idle, 1 fetch grant, 2 data grant

  // Bench RAM: fetch addresses live in 0x00-0x7F, data addresses in 0x80-0xFF.
  logic [31:0] ramMem [256];
  bit          ramWr  [256];
  logic [31:0] refMem [int];

  function automatic logic [31:0] initVal(input logic [7:0] a);
    if (a == 8'h40) return 32'hDEADBEEF;
    return 32'h1000_0000 + ({24'd0, a} * 32'h0001_0101);
  endfunction

  function automatic logic [31:0] refRead(input logic [31:0] a);
    if (refMem.exists(int'(a))) return refMem[int'(a)];
    return initVal(a[7:0]);
  endfunction

  assign bus.ramload = ramWr[bus.ramaddr[7:0]] ? ramMem[bus.ramaddr[7:0]] : initVal(bus.ramaddr[7:0]);

  always @(posedge CLK) begin
    if (bus.ramWEN && bus.ram_ready) begin
      ramMem[bus.ramaddr[7:0]] <= bus.ramstore;
      ramWr[bus.ramaddr[7:0]]  <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic issueI(input logic [31:0] a);
    txn_t t;
    bus.iREN  = 1'b1;
    bus.iaddr = a;
    t.wr   = 1'b0;
    t.addr = a;
    t.data = refRead(a);
    iQ.push_back(t);
  endtask

  task automatic issueD(input logic wr, input logic both, input logic [31:0] a, input logic [31:0] v);
    txn_t t;
    bus.dWEN   = wr;
    bus.dREN   = wr ? both : 1'b1;
    bus.daddr  = a;
    bus.dstore = v;
    t.wr   = wr;
    t.addr = a;
    t.data = wr ? v : refRead(a);
    if (wr) refMem[int'(a)] = v;
    dQ.push_back(t);
  endtask

  // Monitor: scoreboard pops on completions, grant-policy prediction, strobe exclusion.
  initial begin
    txn_t t;
    bit   iDone;
    bit   dDone;
    forever begin
      @(negedge CLK);
      tests++;
      if (bus.ramREN && bus.ramWEN) begin
        fails++;
        $display("FAIL strobe_excl: ramREN=1 and ramWEN=1 together at t=%0t", $time);
      end
      if (!nRST) begin
        served = 0;
        expG   = -1;
      end else begin
        if (expG == 0) begin
          chk("grant_idle", {30'd0, bus.ramREN, bus.ramWEN}, 32'd0);
        end else if (expG == 1) begin
          chk("grant_i_ren", {31'd0, bus.ramREN}, 32'd1);
          chk("grant_i_addr", bus.ramaddr, bus.iaddr);
        end else if (expG == 2) begin
          chk("grant_d_wen", {31'd0, bus.ramWEN}, {31'd0, bus.dWEN});
          chk("grant_d_addr", bus.ramaddr, bus.daddr);
        end
        iDone = bus.iREN && !bus.iwait;
        dDone = (bus.dREN || bus.dWEN) && !bus.dwait;
        if (iDone) begin
          iDoneCnt++;
          if (iQ.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL i_unexpected: completion at 0x%08h, expected no pending fetch", bus.ramaddr);
          end else begin
            t = iQ.pop_front();
            chk("i_addr", bus.ramaddr, t.addr);
            chk("i_ren", {31'd0, bus.ramREN}, 32'd1);
            chk("i_load", bus.iload, t.data);
          end
        end
        if (dDone) begin
          dDoneCnt++;
          if (dQ.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL d_unexpected: completion at 0x%08h, expected no pending data access", bus.ramaddr);
          end else begin
            t = dQ.pop_front();
            chk("d_addr", bus.ramaddr, t.addr);
            chk("d_wen", {31'd0, bus.ramWEN}, {31'd0, t.wr});
            chk("d_ren", {31'd0, bus.ramREN}, {31'd0, ~t.wr});
            chk("d_load", bus.dload, t.wr ? 32'd0 : t.data);
            if (t.wr) chk("d_store", bus.ramstore, t.data);
          end
        end
        if (!bus.iREN || iDone) served = 0;
        else if (dDone && served < 15) served++;
        if (!bus.ramREN && !bus.ramWEN) begin
          if ((bus.dREN || bus.dWEN) && (!bus.iREN || served < LIMIT)) expG = 2;
          else if (bus.iREN) expG = 1;
          else expG = 0;
        end else begin
          expG = -1;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion within bound");
    $fatal(1);
  end

  // Stimulus: directed scenarios, then randomized traffic with a bounded drain.
  initial begin
    bit iAct = 1'b0;
    bit dAct = 1'b0;
    int iSeen;
    int dSeen;
    int got;
    bus.iREN = 1'b0; bus.iaddr = 32'd0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
    bus.daddr = 32'd0; bus.dstore = 32'd0; bus.ram_ready = 1'b0;

    // Requests held through reset, write wins on release.
    #2;
    issueI(32'h05);
    issueD(1'b1, 1'b0, 32'hA1, 32'hCAFE_0001);
    bus.ram_ready = 1'b1;
    tick(); tick(); #1;
    chk("rst_ramREN", {31'd0, bus.ramREN}, 32'd0);
    chk("rst_ramWEN", {31'd0, bus.ramWEN}, 32'd0);
    chk("rst_iwait", {31'd0, bus.iwait}, 32'd1);
    chk("rst_dwait", {31'd0, bus.dwait}, 32'd1);
    chk("rst_ramaddr", bus.ramaddr, 32'd0);
    chk("rst_iload", bus.iload, 32'd0);
    tick(); nRST = 1'b1; #1;
    chk("rel_idle", {30'd0, bus.ramREN, bus.ramWEN}, 32'd0);
    tick(); #1;
    chk("rel_dgnt_wen", {31'd0, bus.ramWEN}, 32'd1);
    chk("rel_dgnt_addr", bus.ramaddr, 32'hA1);
    chk("rel_dgnt_dwait", {31'd0, bus.dwait}, 32'd0);
    tick(); bus.dWEN = 1'b0; #1;
    chk("idle_ready_ignored", {31'd0, bus.iwait}, 32'd1);
    tick(); #1;
    chk("rel_ignt_iwait", {31'd0, bus.iwait}, 32'd0);
    tick(); bus.iREN = 1'b0; bus.ram_ready = 1'b0;

    // Fetch alone with three wait states.
    tick(); issueI(32'h40);
    for (int k = 0; k < 3; k++) begin
      tick(); #1;
      chk("ifetch_ren", {31'd0, bus.ramREN}, 32'd1);
      chk("ifetch_addr", bus.ramaddr, 32'h40);
      chk("ifetch_wait", {31'd0, bus.iwait}, 32'd1);
    end
    tick(); bus.ram_ready = 1'b1; #1;
    chk("ifetch_last_addr", bus.ramaddr, 32'h40);
    chk("ifetch_last_wait", {31'd0, bus.iwait}, 32'd0);
    chk("ifetch_load", bus.iload, 32'hDEADBEEF);
    tick(); bus.iREN = 1'b0; bus.ram_ready = 1'b0; #1;
    chk("ifetch_idle", {30'd0, bus.ramREN, bus.ramWEN}, 32'd0);

    // Simultaneous requests: data first.
    tick(); bus.ram_ready = 1'b1; issueI(32'h11); issueD(1'b0, 1'b0, 32'h90, 32'd0);
    tick(); #1;
    chk("prio_d_addr", bus.ramaddr, 32'h90);
    chk("prio_iwait", {31'd0, bus.iwait}, 32'd1);
    chk("prio_dwait", {31'd0, bus.dwait}, 32'd0);
    tick(); bus.dREN = 1'b0;
    tick(); #1;
    chk("prio_i_addr", bus.ramaddr, 32'h11);
    chk("prio_i_wait", {31'd0, bus.iwait}, 32'd0);
    tick(); bus.iREN = 1'b0;

    // Starvation: fetch held while data keeps re-requesting.
    tick(); issueI(32'h12); issueD(1'b0, 1'b0, 32'h80, 32'd0);
    for (int g = 0; g < 6; g++) begin
      tick(); #1;
      if ((bus.dREN || bus.dWEN) && !bus.dwait && bus.ramaddr == bus.daddr) got = 2;
      else if (bus.iREN && !bus.iwait && bus.ramaddr == bus.iaddr) got = 1;
      else got = 0;
      chk("starve_seq", 32'(got), ((g % (LIMIT + 1)) == LIMIT) ? 32'd1 : 32'd2);
      tick();
      if (g == 5) bus.dREN = 1'b0;
      else if (got == 2) issueD(1'b0, 1'b0, 32'h81 + 32'(g), 32'd0);
      else if (got == 1) issueI(32'h12);
    end
    tick(); #1;
    chk("starve_tail_iwait", {31'd0, bus.iwait}, 32'd0);
    tick(); bus.iREN = 1'b0; bus.ram_ready = 1'b0;

    // Abort of a data grant, pending fetch follows.
    tick(); issueI(32'h13); bus.dREN = 1'b1; bus.daddr = 32'h85;
    tick(); #1;
    chk("abort_dgnt_addr", bus.ramaddr, 32'h85);
    chk("abort_dgnt_dwait", {31'd0, bus.dwait}, 32'd1);
    tick(); bus.dREN = 1'b0;
    tick(); #1;
    chk("abort_idle", {30'd0, bus.ramREN, bus.ramWEN}, 32'd0);
    chk("abort_idle_iwait", {31'd0, bus.iwait}, 32'd1);
    tick(); bus.ram_ready = 1'b1; #1;
    chk("abort_ignt_addr", bus.ramaddr, 32'h13);
    chk("abort_ignt_iwait", {31'd0, bus.iwait}, 32'd0);
    tick(); bus.iREN = 1'b0; bus.ram_ready = 1'b0;

    // Reset pulse in the middle of a fetch.
    tick(); issueI(32'h14);
    tick(); #1;
    chk("mid_ignt_ren", {31'd0, bus.ramREN}, 32'd1);
    nRST = 1'b0; #2;
    chk("mid_rst_strobes", {30'd0, bus.ramREN, bus.ramWEN}, 32'd0);
    chk("mid_rst_addr", bus.ramaddr, 32'd0);
    chk("mid_rst_iwait", {31'd0, bus.iwait}, 32'd1);
    #3; nRST = 1'b1; #1;
    chk("mid_rel_idle", {30'd0, bus.ramREN, bus.ramWEN}, 32'd0);
    tick(); bus.ram_ready = 1'b1; #1;
    chk("mid_regrant_iwait", {31'd0, bus.iwait}, 32'd0);
    tick(); bus.iREN = 1'b0; bus.ram_ready = 1'b0;

    // Random traffic, then drain outstanding requests.
    tick();
    iSeen = iDoneCnt;
    dSeen = dDoneCnt;
    for (int c = 0; c < 3500; c++) begin
      tick();
      bus.ram_ready = ($urandom_range(9) < 6);
      if (iAct && iDoneCnt != iSeen) begin iSeen = iDoneCnt; iAct = 1'b0; bus.iREN = 1'b0; end
      if (dAct && dDoneCnt != dSeen) begin dSeen = dDoneCnt; dAct = 1'b0; bus.dREN = 1'b0; bus.dWEN = 1'b0; end
      if (c < 3000) begin
        if (!iAct && $urandom_range(1) == 1) begin
          issueI(32'($urandom_range(127)));
          iAct = 1'b1;
        end
        if (!dAct && $urandom_range(2) != 0) begin
          issueD(1'($urandom_range(1)), 1'($urandom_range(1)), 32'h80 + 32'($urandom_range(127)), $urandom());
          dAct = 1'b1;
        end
      end else if (!iAct && !dAct) begin
        break;
      end
    end
    chk("drain_idle", {30'd0, iAct, dAct}, 32'd0);
    chk("iq_empty", 32'(iQ.size()), 32'd0);
    chk("dq_empty", 32'(dQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
